// File: rtl/drawpoint_pkg.sv
// rtl/drawpoint_pkg.sv - shared DrawPoint field widths, point type and frame-buffer write FSM states
package drawpoint_pkg;

  localparam int POS_X_W          = 9;
  localparam int POS_Y_W          = 9;
  localparam int RGB_W            = 12;
  localparam int FRAME_WIDTH_DEF  = 320;
  localparam int FRAME_HEIGHT_DEF = 240;

  typedef struct packed {
    logic [POS_X_W-1:0] posX;
    logic [POS_Y_W-1:0] posY;
    logic [RGB_W-1:0]   rgb12;
  } tsDrawPoint;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } teFbWriteState;

endpackage

// File: rtl/drawpoint_sync_fifo.sv
// rtl/drawpoint_sync_fifo.sv - show-ahead synchronous FIFO; a push is accepted when full if a pop happens in the same cycle
module drawpoint_sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/drawpoint_slave_si.sv
// rtl/drawpoint_slave_si.sv - DrawPoint sink: range-check, address, queue and write points to the frame buffer
// Optional DRAWPOINT_SLAVE_STATS_EN adds saturating accepted/clipped point counters.
module drawpoint_slave_si
  import drawpoint_pkg::*;
#(
  parameter int              FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int              FRAME_HEIGHT = FRAME_HEIGHT_DEF,
  parameter int              ADDR_W       = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int              FIFO_DEPTH   = 8
) (
  input  logic                 csi_clock_clk,
  input  logic                 rsi_reset_reset_n,
  input  logic                 coe_dps_ul1Update,
  input  logic [POS_X_W-1:0]   coe_dps_ul9PosX,
  input  logic [POS_Y_W-1:0]   coe_dps_ul9PosY,
  input  logic [RGB_W-1:0]     coe_dps_ul12Rgb12Data,
  output logic [ADDR_W-1:0]    avm_fb_address,
  output logic                 avm_fb_write,
  output logic [15:0]          avm_fb_writedata,
  output logic [1:0]           avm_fb_byteenable,
  input  logic                 avm_fb_waitrequest,
`ifdef DRAWPOINT_SLAVE_STATS_EN
  output logic [15:0]          ul16AcceptedCount,
  output logic [15:0]          ul16ClippedCount,
`endif
  output logic                 ul1Overflow,
  output logic                 ul1Busy
);

  localparam int ENTRY_W = ADDR_W + RGB_W;

  tsDrawPoint         s1_pt;
  logic               s1_upd;
  logic               s1_inr;
  logic               in_range;
  logic [ADDR_W-1:0]  push_addr;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  teFbWriteState      state;
  teFbWriteState      state_n;
  logic               write_n;

  assign in_range = (int'(coe_dps_ul9PosX) < FRAME_WIDTH) &&
                    (int'(coe_dps_ul9PosY) < FRAME_HEIGHT);

  always_ff @(posedge csi_clock_clk) begin
    if (!rsi_reset_reset_n) begin
      s1_upd <= 1'b0;
      s1_inr <= 1'b0;
      s1_pt  <= '0;
    end else begin
      s1_upd <= coe_dps_ul1Update;
      s1_inr <= in_range;
      s1_pt  <= '{posX: coe_dps_ul9PosX, posY: coe_dps_ul9PosY, rgb12: coe_dps_ul12Rgb12Data};
    end
  end

  // Modulo-2^ADDR_W sum, so a high base address wraps around the frame buffer.
  assign push_addr = BASE_ADDR
                   + ADDR_W'(s1_pt.posY) * ADDR_W'(FRAME_WIDTH)
                   + ADDR_W'(s1_pt.posX);

  assign push_req = s1_upd && s1_inr;
  assign push_ok  = push_req && (!fifo_full || pop);

  drawpoint_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (csi_clock_clk),
    .resetn (rsi_reset_reset_n),
    .push   (push_ok),
    .wdata  ({push_addr, s1_pt.rgb12}),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    write_n = avm_fb_write;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          write_n = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (!avm_fb_waitrequest) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            write_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge csi_clock_clk) begin
    if (!rsi_reset_reset_n) begin
      state            <= IDLE;
      avm_fb_write     <= 1'b0;
      avm_fb_address   <= '0;
      avm_fb_writedata <= '0;
      ul1Overflow      <= 1'b0;
    end else begin
      state        <= state_n;
      avm_fb_write <= write_n;
      if (pop) begin
        avm_fb_address   <= head[ENTRY_W-1:RGB_W];
        avm_fb_writedata <= {4'h0, head[RGB_W-1:0]};
      end
      if (push_req && !push_ok) ul1Overflow <= 1'b1;
    end
  end

  assign avm_fb_byteenable = 2'b11;
  assign ul1Busy           = !fifo_empty || avm_fb_write || s1_upd;

`ifdef DRAWPOINT_SLAVE_STATS_EN
  always_ff @(posedge csi_clock_clk) begin
    if (!rsi_reset_reset_n) begin
      ul16AcceptedCount <= '0;
      ul16ClippedCount  <= '0;
    end else begin
      if (push_ok && ul16AcceptedCount != 16'hFFFF)
        ul16AcceptedCount <= ul16AcceptedCount + 1'b1;
      if (s1_upd && !s1_inr && ul16ClippedCount != 16'hFFFF)
        ul16ClippedCount <= ul16ClippedCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_drawpoint_slave_si.sv
// tb/tb_drawpoint_slave_si.sv - scoreboard bench for drawpoint_slave_si
module tb_drawpoint_slave_si;

  logic        clk = 1'b0;
  logic        rstn;
  logic        upd, upd_hi;
  logic [8:0]  px, py;
  logic [11:0] prgb;
  logic        waitreq;
  logic        waitreq_hi;

  logic [16:0] fb_addr, fb_addr_hi;
  logic        fb_wr, fb_wr_hi;
  logic [15:0] fb_data, fb_data_hi;
  logic [1:0]  fb_be, fb_be_hi;
  logic        ovf, ovf_hi, busy, busy_hi;
`ifdef DRAWPOINT_SLAVE_STATS_EN
  logic [15:0] acc_cnt_o, clip_cnt_o, acc_cnt_hi, clip_cnt_hi;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_hi[$];
  logic [32:0] exp_w, exp_w_hi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  drawpoint_slave_si u_dut (
    .csi_clock_clk         (clk),
    .rsi_reset_reset_n     (rstn),
    .coe_dps_ul1Update     (upd),
    .coe_dps_ul9PosX       (px),
    .coe_dps_ul9PosY       (py),
    .coe_dps_ul12Rgb12Data (prgb),
    .avm_fb_address        (fb_addr),
    .avm_fb_write          (fb_wr),
    .avm_fb_writedata      (fb_data),
    .avm_fb_byteenable     (fb_be),
    .avm_fb_waitrequest    (waitreq),
`ifdef DRAWPOINT_SLAVE_STATS_EN
    .ul16AcceptedCount     (acc_cnt_o),
    .ul16ClippedCount      (clip_cnt_o),
`endif
    .ul1Overflow           (ovf),
    .ul1Busy               (busy)
  );

  drawpoint_slave_si #(.BASE_ADDR(17'h1FFFF)) u_dut_hi (
    .csi_clock_clk         (clk),
    .rsi_reset_reset_n     (rstn),
    .coe_dps_ul1Update     (upd_hi),
    .coe_dps_ul9PosX       (px),
    .coe_dps_ul9PosY       (py),
    .coe_dps_ul12Rgb12Data (prgb),
    .avm_fb_address        (fb_addr_hi),
    .avm_fb_write          (fb_wr_hi),
    .avm_fb_writedata      (fb_data_hi),
    .avm_fb_byteenable     (fb_be_hi),
    .avm_fb_waitrequest    (waitreq_hi),
`ifdef DRAWPOINT_SLAVE_STATS_EN
    .ul16AcceptedCount     (acc_cnt_hi),
    .ul16ClippedCount      (clip_cnt_hi),
`endif
    .ul1Overflow           (ovf_hi),
    .ul1Busy               (busy_hi)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepted writes are popped against the expected queue in arrival order.
  always @(negedge clk) begin
    if (rstn && fb_wr && !waitreq) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", fb_addr, fb_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("fb_write", {31'd0, fb_addr, fb_data}, {31'd0, exp_w});
      end
      check("byteenable", {62'd0, fb_be}, 64'd3);
      if (acc_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rstn && fb_wr_hi && !waitreq_hi) begin
      if (exp_hi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_hi: got addr %0d, expected no write", fb_addr_hi);
      end else begin
        exp_w_hi = exp_hi.pop_front();
        check("fb_write_hi", {31'd0, fb_addr_hi, fb_data_hi}, {31'd0, exp_w_hi});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [11:0] rgb, input bit keep);
    px   = 9'(x);
    py   = 9'(y);
    prgb = rgb;
    upd  = 1'b1;
    if (keep) exp_q.push_back({17'(x + y * 320), 4'h0, rgb});
    tick();
    upd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || busy_hi || exp_q.size() != 0 || exp_hi.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 64'(n < 300), 64'd1);
  endtask

  int n_cyc;

  initial begin
    rstn = 1'b0; upd = 1'b0; upd_hi = 1'b0; px = '0; py = '0; prgb = '0;
    waitreq = 1'b0; waitreq_hi = 1'b0;
    repeat (3) tick();
    check("rst_write", 64'(fb_wr), 64'd0);
    check("rst_addr", 64'(fb_addr), 64'd0);
    check("rst_data", 64'(fb_data), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    tick();

    // single point, latency and busy release
    acc_cnt = 0;
    n_cyc = cyc;
    send(5, 2, 12'hABC, 1'b1);
    repeat (3) tick();
    check("single_busy_n4", 64'(busy), 64'd0);
    check("single_count", 64'(acc_cnt), 64'd1);
    check("single_latency", 64'(first_cyc - n_cyc), 64'd3);
    wait_idle("single");

    // clipping
    acc_cnt = 0;
    send(320, 0, 12'h111, 1'b0);
    send(0, 240, 12'h222, 1'b0);
    repeat (6) tick();
    check("clip_count", 64'(acc_cnt), 64'd0);
    check("clip_ovf", 64'(ovf), 64'd0);
    check("clip_busy", 64'(busy), 64'd0);
`ifdef DRAWPOINT_SLAVE_STATS_EN
    check("clip_stat", 64'(clip_cnt_o), 64'd2);
`endif

    // burst of 8 behind a 20-cycle stall
    acc_cnt = 0;
    waitreq = 1'b1;
    for (int i = 0; i < 8; i++) send(i, 0, 12'(12'h300 + i), 1'b1);
    repeat (12) tick();
    check("burst_stalled_count", 64'(acc_cnt), 64'd0);
    waitreq = 1'b0;
    wait_idle("burst");
    check("burst_count", 64'(acc_cnt), 64'd8);
    check("burst_no_bubble", 64'(last_cyc - first_cyc), 64'd7);
    check("burst_ovf", 64'(ovf), 64'd0);

    // overflow: in-flight write plus 8 queued survive, last 3 dropped
    acc_cnt = 0;
    waitreq = 1'b1;
    for (int i = 0; i < 12; i++) send(i, 3, 12'(12'h500 + i), i < 9);
    repeat (8) tick();
    check("ovf_set", 64'(ovf), 64'd1);
    waitreq = 1'b0;
    wait_idle("ovf");
    check("ovf_count", 64'(acc_cnt), 64'd9);
    check("ovf_sticky", 64'(ovf), 64'd1);

    // reset during a stalled write
    waitreq = 1'b1;
    send(7, 7, 12'h777, 1'b0);
    repeat (4) tick();
    check("rstmid_stalled_write", 64'(fb_wr), 64'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rstmid_write", 64'(fb_wr), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_ovf", 64'(ovf), 64'd0);
    waitreq = 1'b0;
    tick();
    acc_cnt = 0;
    n_cyc = cyc;
    send(5, 2, 12'hABC, 1'b1);
    repeat (3) tick();
    check("rstmid_single_latency", 64'(first_cyc - n_cyc), 64'd3);
    check("rstmid_single_busy", 64'(busy), 64'd0);
    wait_idle("rstmid");

    // maximum coordinate with a base address that wraps
    px = 9'd319; py = 9'd239; prgb = 12'h123;
    upd_hi = 1'b1;
    exp_hi.push_back({17'd76798, 16'h0123});
    tick();
    upd_hi = 1'b0;
    wait_idle("corner");
    check("corner_ovf", 64'(ovf_hi), 64'd0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_hi_drained", 64'(exp_hi.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
